// File: rtl/tri_raster_engine.sv
// Triangle rasteriser: latches a fixed-point triangle, walks its clamped bounding box
// with incrementally updated edge functions and issues one pixel write per covered sample.
module tri_raster_engine #(
    parameter int FB_W    = 20,
    parameter int FB_H    = 20,
    parameter int COORD_W = 16,
    parameter int FRAC    = 4,
    parameter int COLOR_W = 3,
    parameter logic [COLOR_W-1:0] CLEAR_COLOR = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic signed [COORD_W-1:0]  x0,
    input  logic signed [COORD_W-1:0]  y0,
    input  logic signed [COORD_W-1:0]  x1,
    input  logic signed [COORD_W-1:0]  y1,
    input  logic signed [COORD_W-1:0]  x2,
    input  logic signed [COORD_W-1:0]  y2,
    input  logic [COLOR_W-1:0]         in_color,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       clr_screen,
    output logic                       wr_en,
    output logic [$clog2(FB_W)-1:0]    wr_x,
    output logic [$clog2(FB_H)-1:0]    wr_y,
    output logic [COLOR_W-1:0]         wr_color,
    input  logic                       wr_ready,
    output logic                       busy,
    output logic                       done
);
    // state | meaning
    // IDLE  | waiting; accepts a triangle or a clear request
    // SETUP | one cycle: bounding box, signed area, edge values at the first box pixel
    // SCAN  | walks the box row-major, one pixel per cycle unless a write is stalled
    // CLEAR | writes CLEAR_COLOR to every framebuffer pixel row-major

    localparam int XW = $clog2(FB_W);
    localparam int YW = $clog2(FB_H);
    localparam int EW = 2 * COORD_W + 4;
    localparam logic signed [COORD_W-1:0] X_HI = COORD_W'(FB_W - 1);
    localparam logic signed [COORD_W-1:0] Y_HI = COORD_W'(FB_H - 1);
    localparam logic [XW-1:0] X_LAST = XW'(FB_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(FB_H - 1);
    localparam logic signed [EW-1:0] HALF = EW'(1) << (FRAC - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SCAN, CLEAR} state_t;

    function automatic logic signed [EW-1:0] ext(input logic signed [COORD_W-1:0] v);
        return {{(EW - COORD_W){v[COORD_W-1]}}, v};
    endfunction

    function automatic logic signed [COORD_W-1:0] min3(input logic signed [COORD_W-1:0] a,
                                                       input logic signed [COORD_W-1:0] b,
                                                       input logic signed [COORD_W-1:0] c);
        logic signed [COORD_W-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic signed [COORD_W-1:0] max3(input logic signed [COORD_W-1:0] a,
                                                       input logic signed [COORD_W-1:0] b,
                                                       input logic signed [COORD_W-1:0] c);
        logic signed [COORD_W-1:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    function automatic logic signed [COORD_W-1:0] clamp(input logic signed [COORD_W-1:0] v,
                                                        input logic signed [COORD_W-1:0] hi);
        if (v[COORD_W-1])
            return '0;
        if (v > hi)
            return hi;
        return v;
    endfunction

    function automatic logic signed [EW-1:0] edge_fn(input logic signed [EW-1:0] xa,
                                                     input logic signed [EW-1:0] ya,
                                                     input logic signed [EW-1:0] xb,
                                                     input logic signed [EW-1:0] yb,
                                                     input logic signed [EW-1:0] px,
                                                     input logic signed [EW-1:0] py);
        return (xb - xa) * (py - ya) - (yb - ya) * (px - xa);
    endfunction

    // Zero counts as covered for either winding, so edge samples are inclusive.
    function automatic logic covered(input logic signed [EW-1:0] a,
                                     input logic signed [EW-1:0] b,
                                     input logic signed [EW-1:0] c,
                                     input logic neg);
        if (neg)
            return (a[EW-1] || a == '0) && (b[EW-1] || b == '0) && (c[EW-1] || c == '0);
        return !a[EW-1] && !b[EW-1] && !c[EW-1];
    endfunction

    state_t                    state;
    logic signed [COORD_W-1:0] vx [3];
    logic signed [COORD_W-1:0] vy [3];
    logic [XW-1:0]             bx_min, bx_max;
    logic [YW-1:0]             by_max;
    logic                      area_neg;
    logic signed [EW-1:0]      e_cur [3];
    logic signed [EW-1:0]      e_row [3];

    logic signed [EW-1:0]      xe [3];
    logic signed [EW-1:0]      ye [3];
    logic signed [COORD_W-1:0] fx_lo, fx_hi, fy_lo, fy_hi;
    logic                      off_screen;
    logic [XW-1:0]             sx_min, sx_max;
    logic [YW-1:0]             sy_min, sy_max;
    logic signed [EW-1:0]      px0, py0, area_c;
    logic signed [EW-1:0]      e_init [3];
    logic signed [EW-1:0]      e_nxt [3];
    logic signed [EW-1:0]      xstep [3];
    logic signed [EW-1:0]      ystep [3];
    logic                      row_end;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            xe[i] = ext(vx[i]);
            ye[i] = ext(vy[i]);
        end
        fx_lo = min3(vx[0], vx[1], vx[2]) >>> FRAC;
        fx_hi = max3(vx[0], vx[1], vx[2]) >>> FRAC;
        fy_lo = min3(vy[0], vy[1], vy[2]) >>> FRAC;
        fy_hi = max3(vy[0], vy[1], vy[2]) >>> FRAC;
        off_screen = fx_hi[COORD_W-1] || fy_hi[COORD_W-1] || (fx_lo > X_HI) || (fy_lo > Y_HI);
        sx_min = XW'(clamp(fx_lo, X_HI));
        sx_max = XW'(clamp(fx_hi, X_HI));
        sy_min = YW'(clamp(fy_lo, Y_HI));
        sy_max = YW'(clamp(fy_hi, Y_HI));
        px0 = ({{(EW - XW){1'b0}}, sx_min} << FRAC) + HALF;
        py0 = ({{(EW - YW){1'b0}}, sy_min} << FRAC) + HALF;
        area_c = edge_fn(xe[0], ye[0], xe[1], ye[1], xe[2], ye[2]);
        row_end = (wr_x == bx_max);
        // One pixel step moves the sample by 1<<FRAC, so each step is a fixed delta.
        for (int i = 0; i < 3; i++) begin
            e_init[i] = edge_fn(xe[i], ye[i], xe[(i + 1) % 3], ye[(i + 1) % 3], px0, py0);
            xstep[i]  = -((ye[(i + 1) % 3] - ye[i]) <<< FRAC);
            ystep[i]  = (xe[(i + 1) % 3] - xe[i]) <<< FRAC;
            e_nxt[i]  = row_end ? e_row[i] + ystep[i] : e_cur[i] + xstep[i];
        end
    end

    assign in_ready = reset && (state == IDLE) && !clr_screen;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            wr_en    <= 1'b0;
            wr_x     <= '0;
            wr_y     <= '0;
            wr_color <= '0;
            done     <= 1'b0;
            bx_min   <= '0;
            bx_max   <= '0;
            by_max   <= '0;
            area_neg <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                vx[i]    <= '0;
                vy[i]    <= '0;
                e_cur[i] <= '0;
                e_row[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr_screen) begin
                        state    <= CLEAR;
                        wr_en    <= 1'b1;
                        wr_x     <= '0;
                        wr_y     <= '0;
                        wr_color <= CLEAR_COLOR;
                    end else if (in_valid) begin
                        state    <= SETUP;
                        vx[0]    <= x0;
                        vy[0]    <= y0;
                        vx[1]    <= x1;
                        vy[1]    <= y1;
                        vx[2]    <= x2;
                        vy[2]    <= y2;
                        wr_color <= in_color;
                    end
                end
                SETUP: begin
                    bx_min   <= sx_min;
                    bx_max   <= sx_max;
                    by_max   <= sy_max;
                    area_neg <= area_c[EW-1];
                    if (area_c == '0 || off_screen) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else begin
                        state <= SCAN;
                        wr_x  <= sx_min;
                        wr_y  <= sy_min;
                        wr_en <= covered(e_init[0], e_init[1], e_init[2], area_c[EW-1]);
                        for (int i = 0; i < 3; i++) begin
                            e_cur[i] <= e_init[i];
                            e_row[i] <= e_init[i];
                        end
                    end
                end
                SCAN: begin
                    if (!wr_en || wr_ready) begin
                        if (row_end && wr_y == by_max) begin
                            state <= IDLE;
                            wr_en <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            wr_en <= covered(e_nxt[0], e_nxt[1], e_nxt[2], area_neg);
                            for (int i = 0; i < 3; i++)
                                e_cur[i] <= e_nxt[i];
                            if (row_end) begin
                                wr_x <= bx_min;
                                wr_y <= wr_y + YW'(1);
                                for (int i = 0; i < 3; i++)
                                    e_row[i] <= e_nxt[i];
                            end else begin
                                wr_x <= wr_x + XW'(1);
                            end
                        end
                    end
                end
                CLEAR: begin
                    if (wr_ready) begin
                        if (wr_x == X_LAST && wr_y == Y_LAST) begin
                            state <= IDLE;
                            wr_en <= 1'b0;
                            done  <= 1'b1;
                        end else if (wr_x == X_LAST) begin
                            wr_x <= '0;
                            wr_y <= wr_y + YW'(1);
                        end else begin
                            wr_x <= wr_x + XW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tri_raster_engine.sv
// Scoreboard bench for tri_raster_engine: a direct edge-function model fills the
// expected-write queue; a negedge monitor pops and compares every accepted write.
module tb_tri_raster_engine;
    localparam int FB_W = 20, FB_H = 20, COORD_W = 16, FRAC = 4, COLOR_W = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic signed [COORD_W-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0, x2 = '0, y2 = '0;
    logic [COLOR_W-1:0] in_color = '0;
    logic in_valid = 1'b0, clr_screen = 1'b0, wr_ready = 1'b1;
    logic in_ready, wr_en, busy, done;
    logic [4:0] wr_x, wr_y;
    logic [COLOR_W-1:0] wr_color;

    tri_raster_engine #(.FB_W(FB_W), .FB_H(FB_H), .COORD_W(COORD_W), .FRAC(FRAC),
                        .COLOR_W(COLOR_W), .CLEAR_COLOR(3'd0)) dut (
        .clk(clk), .reset(reset),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1), .x2(x2), .y2(y2),
        .in_color(in_color), .in_valid(in_valid), .in_ready(in_ready),
        .clr_screen(clr_screen),
        .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color), .wr_ready(wr_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    logic [12:0] exp_q[$];

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint efn(input longint xa, input longint ya, input longint xb,
                                   input longint yb, input longint px, input longint py);
        return (xb - xa) * (py - ya) - (yb - ya) * (px - xa);
    endfunction

    // monitor
    int cyc = 0, acc_cnt = 0, acc_cyc = 0, first_wr_cyc = -1;
    int done_cnt = 0, done_cyc = 0, wr_cnt = 0;
    logic hold_prev = 1'b0;
    logic [12:0] prev_w = '0;

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_wr_en", wr_en, 1);
                check("hold_wr_data", {wr_x, wr_y, wr_color}, prev_w);
            end
            if (in_valid && in_ready) begin
                acc_cnt++;
                acc_cyc = cyc;
                first_wr_cyc = -1;
            end
            if (wr_en && first_wr_cyc < 0)
                first_wr_cyc = cyc;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (wr_en && wr_ready) begin
                wr_cnt++;
                if (exp_q.size() == 0)
                    check("extra_write_wr_en", wr_en, 0);
                else
                    check("write_xyc", {wr_x, wr_y, wr_color}, exp_q.pop_front());
            end
            hold_prev = wr_en && !wr_ready;
            prev_w = {wr_x, wr_y, wr_color};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 50 && !in_ready; i++)
            tick();
        check("in_ready_idle", in_ready, 1);
    endtask

    // Pushes the model's writes, submits the triangle and returns the expected count.
    task automatic submit(input int ax, input int ay, input int bx, input int by,
                          input int cx, input int cy, input logic [2:0] c, output int n);
        longint area, sx, sy, e0, e1, e2;
        n = 0;
        area = efn(ax, ay, bx, by, cx, cy);
        for (int y = 0; y < FB_H; y++) begin
            for (int x = 0; x < FB_W; x++) begin
                sx = longint'(x * 16 + 8);
                sy = longint'(y * 16 + 8);
                e0 = efn(ax, ay, bx, by, sx, sy);
                e1 = efn(bx, by, cx, cy, sx, sy);
                e2 = efn(cx, cy, ax, ay, sx, sy);
                if ((area > 0 && e0 >= 0 && e1 >= 0 && e2 >= 0) ||
                    (area < 0 && e0 <= 0 && e1 <= 0 && e2 <= 0)) begin
                    exp_q.push_back({5'(x), 5'(y), c});
                    n++;
                end
            end
        end
        wait_ready();
        x0 = 16'(ax); y0 = 16'(ay); x1 = 16'(bx); y1 = 16'(by); x2 = 16'(cx); y2 = 16'(cy);
        in_color = c;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("busy_after_accept", busy, 1);
    endtask

    task automatic run_tri(input string name, input int ax, input int ay, input int bx,
                           input int by, input int cx, input int cy, input logic [2:0] c,
                           input bit stall, input bit lat_chk);
        int n, d0, w0, stall_left;
        d0 = done_cnt;
        w0 = wr_cnt;
        stall_left = stall ? 5 : 0;
        submit(ax, ay, bx, by, cx, cy, c, n);
        for (int i = 0; i < 2000 && done_cnt == d0; i++) begin
            tick();
            wr_ready = 1'b1;
            if (stall_left > 0 && wr_cnt - w0 >= 2) begin
                wr_ready = 1'b0;
                stall_left--;
            end
        end
        wr_ready = 1'b1;
        repeat (3) tick();
        check({name, "_done_pulses"}, done_cnt - d0, 1);
        check({name, "_write_count"}, wr_cnt - w0, n);
        check({name, "_queue_left"}, exp_q.size(), 0);
        check({name, "_busy_end"}, busy, 0);
        if (n == 0)
            check({name, "_done_latency"}, done_cyc - acc_cyc, 2);
        else if (lat_chk)
            check({name, "_first_wr_latency"}, first_wr_cyc - acc_cyc, 2);
    endtask

    task automatic run_clear();
        int d0, w0, a0;
        d0 = done_cnt;
        w0 = wr_cnt;
        for (int y = 0; y < FB_H; y++)
            for (int x = 0; x < FB_W; x++)
                exp_q.push_back({5'(x), 5'(y), 3'd0});
        wait_ready();
        a0 = acc_cnt;
        x0 = 16'sd0; y0 = 16'sd0; x1 = 16'sd64; y1 = 16'sd0; x2 = 16'sd0; y2 = 16'sd64;
        in_color = 3'd5;
        in_valid = 1'b1;
        clr_screen = 1'b1;
        #1;
        check("clr_in_ready_low", in_ready, 0);
        tick();
        in_valid = 1'b0;
        clr_screen = 1'b0;
        for (int i = 0; i < 3000 && done_cnt == d0; i++) begin
            tick();
            wr_ready = ($urandom_range(0, 3) != 0);
        end
        wr_ready = 1'b1;
        repeat (3) tick();
        check("clr_done_pulses", done_cnt - d0, 1);
        check("clr_write_count", wr_cnt - w0, FB_W * FB_H);
        check("clr_tri_not_accepted", acc_cnt - a0, 0);
        check("clr_queue_left", exp_q.size(), 0);
        check("clr_in_ready_after", in_ready, 1);
    endtask

    task automatic run_reset_abort();
        int n, d0, w0;
        d0 = done_cnt;
        w0 = wr_cnt;
        submit(0, 0, 64, 0, 0, 64, 3'd4, n);
        for (int i = 0; i < 200 && wr_cnt - w0 < 3; i++)
            tick();
        check("rst_writes_before", wr_cnt - w0, 3);
        reset = 1'b0;
        exp_q.delete();
        #1;
        check("rst_wr_en", wr_en, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        repeat (2) tick();
        reset = 1'b1;
        repeat (30) tick();
        check("rst_no_more_writes", wr_cnt - w0, 3);
        check("rst_no_done", done_cnt - d0, 0);
        check("rst_in_ready_after", in_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        check("reset_wr_en", wr_en, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_in_ready", in_ready, 0);
        check("reset_wr_xyc", {wr_x, wr_y, wr_color}, 0);
        reset = 1'b1;
        tick();
        check("in_ready_after_reset", in_ready, 1);

        run_tri("right_tri",   0,   0,  64,   0,   0,  64, 3'd3, 1'b0, 1'b1);
        run_tri("swapped",     0,   0,   0,  64,  64,   0, 3'd6, 1'b0, 1'b1);
        run_tri("collinear",   0,   0,  32,  32,  64,  64, 3'd1, 1'b0, 1'b0);
        run_tri("all_left",  -64,   0, -16,   0, -40,  48, 3'd2, 1'b0, 1'b0);
        run_tri("stalled",     0,   0,  64,   0,   0,  64, 3'd5, 1'b1, 1'b1);
        run_tri("clipped",   -40, -24, 200,  40,  60, 360, 3'd7, 1'b0, 1'b0);
        run_tri("fraction",   37,  21, 150,  90,  20, 130, 3'd2, 1'b1, 1'b0);
        run_clear();
        run_reset_abort();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/tri_raster_engine.md
TRI_RASTER_ENGINE -- requirements
Module: tri_raster_engine

Interface
REQ-001 SHALL have parameter FB_W, default 20, framebuffer width in pixels.
REQ-002 SHALL have parameter FB_H, default 20, framebuffer height in pixels.
REQ-003 SHALL have parameter COORD_W, default 16, signed vertex coordinate width.
REQ-004 SHALL have parameter FRAC, default 4 (>=1), fractional bits of vertex coordinates.
REQ-005 SHALL have parameter COLOR_W, default 3, pixel colour width; CLEAR_COLOR, default 0, colour used by clear.
REQ-006 SHALL have port clk, input, 1, single clock; all state on its rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-008 SHALL have ports x0,y0,x1,y1,x2,y2, input, COORD_W each, signed fixed-point vertices.
REQ-009 SHALL have ports in_color (input, COLOR_W), in_valid (input, 1), and in_ready (output, 1) for triangle submission.
REQ-010 SHALL have port clr_screen, input, 1, framebuffer clear request.
REQ-011 SHALL have ports wr_en (output, 1), wr_x (output, clog2(FB_W)), wr_y (output, clog2(FB_H)), wr_color (output, COLOR_W), and wr_ready (input, 1) as the pixel write port.
REQ-012 SHALL have ports busy (output, 1, high when not IDLE) and done (output, 1, one-cycle completion pulse).

Function
REQ-013 SHALL implement states IDLE, SETUP, SCAN, CLEAR.
REQ-014 in_ready SHALL be high only in IDLE with clr_screen low; a triangle is accepted when in_valid and in_ready are both high, latching all vertices and in_color.
REQ-015 In IDLE with clr_screen high, SHALL enter CLEAR; clr_screen SHALL win over a simultaneous in_valid, and that triangle SHALL NOT be accepted.
REQ-016 SETUP SHALL last exactly 1 cycle and compute the bounding box: floor (arithmetic shift by FRAC) of the vertex min/max, clamped to [0,FB_W-1] x [0,FB_H-1].
REQ-017 SETUP SHALL compute area = (x1-x0)(y2-y0)-(y1-y0)(x2-x0) at full precision (2*COORD_W+2 bits, no truncation).
REQ-018 If area==0, or the unclamped box lies wholly off-screen, SHALL go SETUP->IDLE with no writes and pulse done.
REQ-019 SCAN SHALL visit every box pixel once in row-major order (x fastest), at most one pixel per cycle.
REQ-020 Sample point SHALL be the pixel centre: (p<<FRAC) + (1<<(FRAC-1)).
REQ-021 Edge functions E01, E12, E20 (E_ab(p)=(xb-xa)(py-ya)-(yb-ya)(px-xa)) SHALL be updated incrementally: add a constant per x step, reload per row; results SHALL equal direct evaluation exactly.
REQ-022 A pixel is inside iff all three E>=0 when area>0, or all three E<=0 when area<0; edge samples are inclusive.
REQ-023 For an inside pixel, SHALL assert wr_en with wr_x, wr_y, wr_color=latched colour; outside pixels produce no write.
REQ-024 When wr_en is high and wr_ready is low, SHALL hold wr_en, wr_x, wr_y, wr_color stable and not advance the scan.
REQ-025 First possible wr_en SHALL occur 2 cycles after acceptance (accept cycle 0, SETUP 1, SCAN 2).
REQ-026 After the last box pixel is evaluated and its write (if any) is taken, SHALL return to IDLE and pulse done for 1 cycle.
REQ-027 CLEAR SHALL write CLEAR_COLOR to all FB_W*FB_H pixels in row-major order, obeying REQ-024, then return to IDLE with a done pulse.
REQ-028 wr_en SHALL be low in IDLE and SETUP.

Reset
REQ-029 While reset is low: state=IDLE, wr_en=0, done=0, busy=0, in_ready=0, wr_x=0, wr_y=0, wr_color=0.
REQ-030 Reset asserted mid-SCAN or mid-CLEAR SHALL abort immediately with no further writes and no done pulse; after release in_ready=1 when clr_screen is low.

Verification
REQ-031 Defaults, wr_ready=1, vertices (0,0),(64,0),(0,64) (pixels (0,0),(4,0),(0,4)) -> exactly 10 writes, the pixels with x+y<=3, row-major, first wr_en at cycle 2, done after.
REQ-032 Same triangle with vertices 1 and 2 swapped (area<0) -> the same 10 writes.
REQ-033 Collinear (0,0),(32,32),(64,64), or triangle with all x<0 -> 0 writes, done 2 cycles after acceptance.
REQ-034 clr_screen and in_valid high together in IDLE -> triangle not accepted, 400 writes of colour 0, done.
REQ-035 wr_ready low for 5 cycles during REQ-031 -> outputs held stable, the same 10 writes, none lost or duplicated.
REQ-036 Reset pulsed after the 3rd write of REQ-031 -> no further writes, no done pulse, in_ready high after release.
